// File: rtl/shift_register_pkg.sv
// Shared constants for the serial shift register primitive.
`timescale 1ns/100ps
package shift_register_pkg;
    localparam int unsigned DEPTH_MIN = 1;
    localparam int unsigned DEPTH_MAX = 64;
endpackage

// File: rtl/shift_stage.sv
// Single shift register stage: one D flop with synchronous active-high clear.
`timescale 1ns/100ps
module shift_stage (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    // Capture d on every edge; reset overrides the data bit.
    always_ff @(posedge clk) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end
endmodule

// File: rtl/shift_register.sv
// Serial-in, serial-out shift register of DEPTH stages with a parallel tap.
// q[0] holds the newest bit and q[DEPTH-1] the oldest; out is the oldest stage.
`timescale 1ns/100ps
module shift_register
    import shift_register_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             in,
    output logic             out,
    input  logic             clk,
    input  logic             rst,
    output logic [DEPTH-1:0] q
);
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("shift_register: DEPTH out of range 1..64");
    end

    logic [DEPTH-1:0] stage;
    logic [DEPTH-1:0] feed;

    // Stage 0 is fed from the serial input, every later stage from its predecessor.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign feed[k] = in;
        end else begin : g_body
            assign feed[k] = stage[k-1];
        end
        shift_stage u_stage (
            .clk (clk),
            .rst (rst),
            .d   (feed[k]),
            .q   (stage[k])
        );
    end

    assign out = stage[DEPTH-1];
    assign q   = stage;
endmodule

// File: tb/tb_shift_register.sv
// Directed bench for shift_register at DEPTH 1, 4 and 8 driven from shared stimulus.
`timescale 1ns/100ps
module tb_shift_register;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       out1, out4, out8;
    logic [0:0] q1;
    logic [3:0] q4;
    logic [7:0] q8;
    int         tests = 0;
    int         fails = 0;

    always #2 clk = ~clk;

    shift_register #(.DEPTH(1)) dut1 (.in(din), .out(out1), .clk(clk), .rst(rst), .q(q1));
    shift_register #(.DEPTH(4)) dut4 (.in(din), .out(out4), .clk(clk), .rst(rst), .q(q4));
    shift_register #(.DEPTH(8)) dut8 (.in(din), .out(out8), .clk(clk), .rst(rst), .q(q8));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pattern 0,1,0,0,1,1 then zeros; expected outputs per edge t=0..13.
    logic pat  [14] = '{0,1,0,0,1,1,0,0,0,0,0,0,0,0};
    logic exp1 [14] = '{0,1,0,0,1,1,0,0,0,0,0,0,0,0};
    logic exp4 [14] = '{0,0,0,0,1,0,0,1,1,0,0,0,0,0};
    logic exp8 [14] = '{0,0,0,0,0,0,0,0,1,0,0,1,1,0};
    logic gl   [4]  = '{1,0,1,1};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic o;
        logic nxt;
        // Reset with in=1 for two edges.
        rst = 1'b1; din = 1'b1;
        tick(); tick();
        check("rst_q4", q4, 4'b0000);
        check("rst_out4", out4, 1'b0);
        check("rst_q1", q1, 1'b0);
        check("rst_q8", q8, 8'h00);

        // Impulse walks through DEPTH=4.
        rst = 1'b0; din = 1'b1;
        tick(); check("imp_q4_e1", q4, 4'b0001); check("imp_out1_e1", out1, 1'b1);
        din = 1'b0;
        tick(); check("imp_q4_e2", q4, 4'b0010); check("imp_out1_e2", out1, 1'b0);
        tick(); check("imp_q4_e3", q4, 4'b0100); check("imp_out4_e3", out4, 1'b0);
        tick(); check("imp_q4_e4", q4, 4'b1000); check("imp_out4_e4", out4, 1'b1);
        tick(); check("imp_q4_e5", q4, 4'b0000); check("imp_out4_e5", out4, 1'b0);

        // Pattern across all three depths.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int t = 0; t < 14; t++) begin
            din = pat[t];
            tick();
            check($sformatf("pat_out1_t%0d", t), out1, exp1[t]);
            check($sformatf("pat_out4_t%0d", t), out4, exp4[t]);
            check($sformatf("pat_out8_t%0d", t), out8, exp8[t]);
            if (t == 5) begin
                check("pat_q4_t5", q4, 4'b0011);
                check("pat_q8_t5", q8, 8'b0001_0011);
            end
        end

        // Mid-stream reset: load 1,1,1 then reset with in=1.
        din = 1'b1;
        tick(); tick(); tick();
        check("mid_q4_loaded", q4, 4'b0111);
        rst = 1'b1;
        #1;
        check("mid_rst_no_edge", q4, 4'b0111);
        tick();
        check("mid_q4_cleared", q4, 4'b0000);
        check("mid_q8_cleared", q8, 8'h00);
        check("mid_q1_cleared", q1, 1'b0);
        rst = 1'b0; din = 1'b1;
        tick(); check("mid_q4_e1", q4, 4'b0001);
        din = 1'b0;
        tick(); check("mid_out4_e2", out4, 1'b0);
        tick(); check("mid_out4_e3", out4, 1'b0);
        tick(); check("mid_out4_e4", out4, 1'b1); check("mid_q4_e4", q4, 4'b1000);

        // Glitch immunity: only the value held around each rising edge counts.
        rst = 1'b1; tick(); rst = 1'b0;
        din = gl[0];
        for (int c = 0; c < 4; c++) begin
            nxt = (c < 3) ? gl[c+1] : 1'b0;
            @(posedge clk);
            #1 din = ~nxt;
            o = out4;
            @(negedge clk);
            din = nxt;
            #0.5 check($sformatf("glitch_neg_c%0d", c), out4, o);
            #0.5 din = ~nxt;
            #0.5 din = nxt;
        end
        check("glitch_q4", q4, 4'b1011);
        check("glitch_out4", out4, 1'b1);
        check("glitch_q1", q1, 1'b1);
        check("glitch_q8", q8, 8'b0000_1011);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
